alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, registered ALU for the custom CPU datapath, superseding the combinational 32-bit ALU. It adds a valid/ready handshake, correct signed set-less-than, an unsigned compare, and iterative multiply and unsigned divide writing a HI/LO pair. It sits in the EX stage; the control unit stalls the pipeline while `in_ready` is low.

## Interface
- `WIDTH`, 32, operand/result width; legal range 4..64.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs.
- `in_valid`  in  1  operands and opcode are valid this cycle.
- `in_ready`  out  1  block can accept an operation this cycle.
- `alu_control`  in  4  opcode (see Operation).
- `a`, `b`  in  WIDTH each  operands.
- `out_valid`  out  1  one-cycle pulse; result outputs were updated on the preceding edge.
- `alu_out`  out  WIDTH  result; LO half for mul/divu.
- `hi_out`  out  WIDTH  HI half for mul, remainder for divu; unchanged by other ops.
- `zout`  out  1  `alu_out == 0`.
- `overflow`  out  1  signed overflow (add/sub only, else 0).
- `illegal`  out  1  opcode undefined.

## Operation
- Opcodes: 0000 and, 0001 or, 0010 add, 0011 xor, 0100 nor, 0110 sub, 0111 slt (signed), 1000 sltu, 1001 mul (unsigned, 2·WIDTH product → hi_out:alu_out), 1010 divu (alu_out = quotient, hi_out = remainder). All others are illegal: alu_out = 0, zout = 1, illegal = 1, overflow = 0.
- Arithmetic is modulo 2^WIDTH; sub = a + ~b + 1.
- add overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]). sub overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
- slt = diff[MSB] XOR sub-overflow, giving the correct result at extreme operands. sltu = borrow out of a − b. Both zero-extend the 1-bit result.
- mul uses shift-add, one bit per cycle, LSB of multiplier first.
- divu uses restoring division, one quotient bit per cycle, MSB first.
- divu with b = 0: quotient = all ones, remainder = a, illegal = 0.
- FSM states:
  - IDLE: `in_ready` = 1. An accepted single-cycle op stays in IDLE. Accepted mul/divu loads operands, sets the counter to WIDTH, and moves to RUN.
  - RUN: `in_ready` = 0. Performs one iteration per cycle. When the counter reaches 0, writes hi_out/alu_out/zout, pulses out_valid, and returns to IDLE.
- `in_valid` is ignored while in RUN. Operands need not be held after acceptance.
- Outputs hold their last value until the next result write.

## Timing
- Reset values: state IDLE, counter 0, in_ready 1, out_valid 0, alu_out 0, hi_out 0, zout 1, overflow 0, illegal 0.
- Reset mid-RUN aborts immediately; no out_valid is produced.
- Single-cycle ops: accepted at edge E → results and out_valid visible after E, so latency is 1. Back-to-back acceptance is allowed every cycle.
- mul/divu: accepted at edge E0, iterations on edges E1..E_WIDTH. Results and the out_valid pulse follow E_WIDTH, so latency is WIDTH cycles.
- in_ready returns to 1 in the same cycle out_valid pulses; a new op may be accepted on that cycle's edge.
- Iteration counter width is clog2(WIDTH+1). The counter never wraps; it decrements only while in RUN.

## Structure
- Shared package `alu_pkg`: opcode constants (`ALU_AND` … `ALU_DIVU`), FSM state encoding (IDLE/RUN), and the op-class helper distinguishing single- from multi-cycle ops.
- Sub-module `alu_seq_muldiv`: the iterative mul/divu engine, with start/done and hi/lo outputs. The top level holds the FSM-facing handshake, the combinational single-cycle datapath, and the result registers.

## Test plan
- Reset: assert reset for 3 cycles and release → all outputs at reset values, in_ready = 1, no out_valid.
- add 0x7FFFFFFF + 0x00000001 → alu_out 0x80000000, overflow 1, out_valid one cycle later. Then sub 0x80000000 − 1 → 0x7FFFFFFF, overflow 1.
- slt a = 0x80000000, b = 0x7FFFFFFF → 1. sltu a = 0xFFFFFFFF, b = 1 → 0. Opcode 1111 → alu_out 0, zout 1, illegal 1.
- mul 0xFFFFFFFF × 0xFFFFFFFF → after exactly 32 cycles hi_out 0xFFFFFFFE, alu_out 0x00000001. in_ready is low throughout, and an in_valid pulse mid-run is ignored.
- divu 100 / 7 → alu_out 14, hi_out 2. divu 0x1234 / 0 → alu_out 0xFFFFFFFF, hi_out 0x1234.
- Reset asserted at iteration 10 of a divu → outputs cleared asynchronously, in_ready 1, no out_valid. Then 3 back-to-back single-cycle ops → 3 consecutive out_valid pulses with correct results.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and op-class helper for the sequential ALU.
package alu_pkg;
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_MUL  = 4'b1001;
    localparam logic [3:0] ALU_DIVU = 4'b1010;

    typedef enum logic {IDLE, RUN} state_t;

    function automatic logic is_multi(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_DIVU);
    endfunction
endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the EX-stage control and the ALU.
interface alu_seq_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] hi_out;
    logic             zout;
    logic             overflow;
    logic             illegal;

    modport master (output in_valid, alu_control, a, b,
                    input  in_ready, out_valid, alu_out, hi_out, zout, overflow, illegal);
    modport slave  (input  in_valid, alu_control, a, b,
                    output in_ready, out_valid, alu_out, hi_out, zout, overflow, illegal);
endinterface

// File: rtl/alu_seq_muldiv.sv
// Iterative engine: shift-add multiply (LSB first) and restoring divide (MSB first),
// one bit per cycle. hi/lo present the post-iteration value so the last step can be written directly.
module alu_seq_muldiv #(parameter int WIDTH = 32) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic             div_q, div_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] rem_sub;
    logic             borrow;
    logic [WIDTH-1:0] hi_step, lo_step;

    always_comb begin
        mul_sum = {1'b0, hi_q} + ({1'b0, opb_q} & {(WIDTH+1){lo_q[0]}});
        // Remainder stays below the divisor, so the trial difference always fits WIDTH bits.
        shifted = {hi_q, lo_q[WIDTH-1]};
        borrow  = shifted < {1'b0, opb_q};
        rem_sub = shifted[WIDTH-1:0] - opb_q;
        if (div_q) begin
            hi_step = borrow ? shifted[WIDTH-1:0] : rem_sub;
            lo_step = {lo_q[WIDTH-2:0], ~borrow};
        end else begin
            hi_step = mul_sum[WIDTH:1];
            lo_step = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        div_d = div_q;
        opb_d = opb_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        if (start) begin
            cnt_d = CW'(WIDTH);
            div_d = div;
            opb_d = b;
            hi_d  = '0;
            lo_d  = a;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            hi_d  = hi_step;
            lo_d  = lo_step;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            div_q <= 1'b0;
            opb_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
            opb_q <= opb_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    assign done = (cnt_q == CW'(1));
    assign hi   = hi_step;
    assign lo   = lo_step;
endmodule

// File: rtl/alu_seq.sv
// Registered EX-stage ALU: single-cycle logic/arith ops plus iterative mul/divu behind a
// valid/ready handshake. Result registers hold until the next write.
module alu_seq import alu_pkg::*; #(parameter int WIDTH = 32) (
    input  logic      clk,
    input  logic      reset,
    alu_seq_if.slave  bus
);
    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] alu_out_q, alu_out_d;
    logic [WIDTH-1:0] hi_out_q, hi_out_d;
    logic             zout_q, zout_d;
    logic             overflow_q, overflow_d;
    logic             illegal_q, illegal_d;

    logic             accept, md_start, md_done;
    logic [WIDTH-1:0] md_hi, md_lo;
    logic [WIDTH-1:0] sum, res;
    logic [WIDTH:0]   dif;
    logic             ovf_add, ovf_sub, res_ovf, res_ill;

    assign accept   = bus.in_valid && (state_q == IDLE);
    assign md_start = accept && is_multi(bus.alu_control);

    alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk   (clk),
        .reset (reset),
        .start (md_start),
        .div   (bus.alu_control == ALU_DIVU),
        .a     (bus.a),
        .b     (bus.b),
        .done  (md_done),
        .hi    (md_hi),
        .lo    (md_lo)
    );

    always_comb begin
        sum     = bus.a + bus.b;
        // dif[WIDTH] is the carry out of a + ~b + 1; its inverse is the unsigned borrow.
        dif     = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);
        ovf_add = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
        ovf_sub = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (dif[WIDTH-1] != bus.a[WIDTH-1]);
        res     = '0;
        res_ovf = 1'b0;
        res_ill = 1'b0;
        case (bus.alu_control)
            ALU_AND:  res = bus.a & bus.b;
            ALU_OR:   res = bus.a | bus.b;
            ALU_ADD:  begin res = sum; res_ovf = ovf_add; end
            ALU_XOR:  res = bus.a ^ bus.b;
            ALU_NOR:  res = ~(bus.a | bus.b);
            ALU_SUB:  begin res = dif[WIDTH-1:0]; res_ovf = ovf_sub; end
            ALU_SLT:  res = {{(WIDTH-1){1'b0}}, dif[WIDTH-1] ^ ovf_sub};
            ALU_SLTU: res = {{(WIDTH-1){1'b0}}, ~dif[WIDTH]};
            default:  res_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = 1'b0;
        alu_out_d   = alu_out_q;
        hi_out_d    = hi_out_q;
        zout_d      = zout_q;
        overflow_d  = overflow_q;
        illegal_d   = illegal_q;
        case (state_q)
            IDLE: begin
                if (md_start) begin
                    state_d = RUN;
                end else if (accept) begin
                    out_valid_d = 1'b1;
                    alu_out_d   = res;
                    zout_d      = (res == '0);
                    overflow_d  = res_ovf;
                    illegal_d   = res_ill;
                end
            end
            RUN: begin
                if (md_done) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    alu_out_d   = md_lo;
                    hi_out_d    = md_hi;
                    zout_d      = (md_lo == '0);
                    overflow_d  = 1'b0;
                    illegal_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
            hi_out_q    <= '0;
            zout_q      <= 1'b1;
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            alu_out_q   <= alu_out_d;
            hi_out_q    <= hi_out_d;
            zout_q      <= zout_d;
            overflow_q  <= overflow_d;
            illegal_q   <= illegal_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.alu_out   = alu_out_q;
    assign bus.hi_out    = hi_out_q;
    assign bus.zout      = zout_q;
    assign bus.overflow  = overflow_q;
    assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: the driver queues hand-computed results with their due cycle,
// a negedge monitor pops and compares on every out_valid.
module tb_alu_seq;
    import alu_pkg::*;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus();
    alu_seq #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         z;
        logic         ov;
        logic         il;
        int           due;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out_valid: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("alu_out", 64'(bus.alu_out), 64'(e.lo));
                chk("hi_out", 64'(bus.hi_out), 64'(e.hi));
                chk("zout", 64'(bus.zout), 64'(e.z));
                chk("overflow", 64'(bus.overflow), 64'(e.ov));
                chk("illegal", 64'(bus.illegal), 64'(e.il));
                chk("latency_cycle", 64'(cyc), 64'(e.due));
                chk("in_ready_at_result", 64'(bus.in_ready), 64'd1);
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [W-1:0] elo, input logic [W-1:0] ehi,
                         input logic ez, input logic eov, input logic eil);
        int n;
        exp_t e;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout: in_ready got %b expected 1", bus.in_ready);
            return;
        end
        bus.in_valid = 1'b1;
        bus.alu_control = op;
        bus.a = ia;
        bus.b = ib;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        e.lo = elo; e.hi = ehi; e.z = ez; e.ov = eov; e.il = eil;
        e.due = cyc + (is_multi(op) ? W : 0);
        sb.push_back(e);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_alu_out"}, 64'(bus.alu_out), 64'd0);
        chk({tag, "_hi_out"}, 64'(bus.hi_out), 64'd0);
        chk({tag, "_zout"}, 64'(bus.zout), 64'd1);
        chk({tag, "_overflow"}, 64'(bus.overflow), 64'd0);
        chk({tag, "_illegal"}, 64'(bus.illegal), 64'd0);
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.alu_control = 4'h0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk_reset_state("reset");

        issue(ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 1'b0, 1'b1, 1'b0);
        issue(ALU_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 1'b0, 1'b1, 1'b0);
        issue(ALU_SLT,  32'h80000000, 32'h7FFFFFFF, 32'h00000001, 32'h0, 1'b0, 1'b0, 1'b0);
        issue(ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0);
        issue(4'b1111,  32'h12345678, 32'h9ABCDEF0, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b1);
        issue(ALU_ADD,  32'h00000005, 32'h00000003, 32'h00000008, 32'h0, 1'b0, 1'b0, 1'b0);

        // mul: in_ready must stay low for the whole run; a stray in_valid must be ignored
        issue(ALU_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        bus.alu_control = ALU_ADD;
        for (int i = 0; i < W; i++) begin
            chk("in_ready_low_during_mul", 64'(bus.in_ready), 64'd0);
            bus.in_valid = (i == 5);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;

        issue(ALU_DIVU, 32'd100,      32'd7, 32'd14,       32'd2,      1'b0, 1'b0, 1'b0);
        issue(ALU_DIVU, 32'h00001234, 32'd0, 32'hFFFFFFFF, 32'h1234,   1'b0, 1'b0, 1'b0);

        // abort a divu after 10 iterations with an asynchronous reset
        issue(ALU_DIVU, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #3 reset = 1'b1;
        sb.delete();
        #1 chk_reset_state("midrun_reset");
        @(posedge clk); #1 reset = 1'b0;

        issue(ALU_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0, 1'b0, 1'b0, 1'b0);
        issue(ALU_OR,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 32'h0, 1'b0, 1'b0, 1'b0);
        issue(ALU_NOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 32'h0, 1'b0, 1'b0, 1'b0);
        issue(ALU_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 32'h0, 1'b0, 1'b0, 1'b0);

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (40) @(posedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
